// File: rtl/argmax_arb_pkg.sv
// Shared types and constants for the argmax arbiter: FSM state encoding,
// engine result width and the watchdog error code.
package argmax_arb_pkg;

  localparam int RESULT_W = 32;
  localparam logic [RESULT_W-1:0] ERR_CODE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first set request found when
// searching upward from i_ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_found
);

  logic [IDX_W-1:0] cand_s;

  // Scan candidates in priority order starting at the pointer.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_found     = 1'b0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_found && i_req[cand_s]) begin
        o_grant[cand_s] = 1'b1;
        o_grant_idx     = cand_s;
        o_found         = 1'b1;
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/argmax_arbiter.sv
// Shares one argmax engine among NUM_REQ requesters: round-robin grant,
// one-shot launch, wait for the result, deliver it to the granted requester.
// Optional engine watchdog enabled by defining ARGMAX_ARB_TIMEOUT_EN.
module argmax_arbiter
  import argmax_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int NUM_INPUT      = 10,
  parameter int INPUT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic [NUM_REQ-1:0]                       i_req_valid,
  output logic [NUM_REQ-1:0]                       o_req_ready,
  input  logic [NUM_REQ*NUM_INPUT*INPUT_WIDTH-1:0] i_req_data,
  output logic [NUM_INPUT*INPUT_WIDTH-1:0]         o_eng_data,
  output logic                                     o_eng_valid,
  input  logic [RESULT_W-1:0]                      i_eng_data,
  input  logic                                     i_eng_data_valid,
  output logic [NUM_REQ-1:0]                       o_rsp_valid,
  output logic [RESULT_W-1:0]                      o_rsp_data,
  output logic                                     o_rsp_err,
  input  logic [NUM_REQ-1:0]                       i_rsp_ready,
  output logic                                     o_busy
);

  localparam int VEC_W = NUM_INPUT * INPUT_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1'b1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("argmax_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [VEC_W-1:0]    data_q, data_d;
  logic                eng_valid_q, eng_valid_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [RESULT_W-1:0] rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  grant_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                found_s;
  logic                xfer_s;
  logic                timeout_s;
  logic                load_rsp_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req       (i_req_valid),
    .i_ptr       (ptr_q),
    .o_grant     (grant_s),
    .o_grant_idx (grant_idx_s),
    .o_found     (found_s)
  );

  // Ready is offered only in IDLE and is held low while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    if ((state_q == ST_IDLE) && i_rst_n) begin
      o_req_ready = grant_s;
    end else begin
      o_req_ready = '0;
    end
  end

  assign xfer_s     = (state_q == ST_IDLE) && found_s;
  assign load_rsp_s = (state_q == ST_WAIT) && (i_eng_data_valid || timeout_s);

`ifdef ARGMAX_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rsp_err_q, rsp_err_d;

  // Counts from the launch cycle so the error lands TIMEOUT_CYCLES after o_eng_valid.
  always_comb begin
    tmr_d     = '0;
    rsp_err_d = rsp_err_q;
    if ((state_q == ST_LAUNCH) || (state_q == ST_WAIT)) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = '0;
    end
    if (load_rsp_s) begin
      rsp_err_d = !i_eng_data_valid;
    end else begin
      rsp_err_d = rsp_err_q;
    end
  end

  assign timeout_s = (state_q == ST_WAIT) && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign o_rsp_err = rsp_err_q;

  // Watchdog state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  // Next-state and datapath for the launch/wait/deliver sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    data_d      = data_q;
    eng_valid_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d     = ST_LAUNCH;
          gnt_idx_d   = grant_idx_s;
          data_d      = i_req_data[grant_idx_s*VEC_W +: VEC_W];
          eng_valid_d = 1'b1;
          ptr_d       = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (load_rsp_s) begin
          state_d     = ST_DELIVER;
          rsp_valid_d = ONE_HOT0 << gnt_idx_q;
          rsp_data_d  = i_eng_data_valid ? i_eng_data : ERR_CODE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DELIVER: begin
        if ((i_rsp_ready & rsp_valid_q) != '0) begin
          state_d     = ST_IDLE;
          rsp_valid_d = '0;
        end else begin
          state_d = ST_DELIVER;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      data_q      <= '0;
      eng_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      data_q      <= data_d;
      eng_valid_q <= eng_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign o_eng_data  = data_q;
  assign o_eng_valid = eng_valid_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_argmax_arbiter.sv
// Directed self-checking bench for argmax_arbiter (default parameters).
// Exercises the watchdog path when built with ARGMAX_ARB_TIMEOUT_EN.
module tb_argmax_arbiter;

  localparam int NR = 4;
  localparam int NI = 10;
  localparam int IW = 16;
  localparam int VW = NI * IW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*VW-1:0]  req_data;
  logic [VW-1:0]     eng_data;
  logic              eng_valid;
  logic [31:0]       eng_res;
  logic              eng_res_valid;
  logic [NR-1:0]     rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic [NR-1:0]     rsp_ready;
  logic              busy;

  int nvec = 0;
  int nerr = 0;
  int mx [NR] = '{3, 7, 0, 9};

  argmax_arbiter #(
    .NUM_REQ(NR), .NUM_INPUT(NI), .INPUT_WIDTH(IW), .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_data(req_data),
    .o_eng_data(eng_data), .o_eng_valid(eng_valid),
    .i_eng_data(eng_res), .i_eng_data_valid(eng_res_valid),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Requester r's vector: small ramp with a single large element at m.
  function automatic logic [VW-1:0] mkvec(input int r, input int m);
    logic [VW-1:0] v;
    for (int e = 0; e < NI; e++)
      v[e*IW +: IW] = (e == m) ? (16'h8000 + 16'(r)) : 16'(e + 1);
    return v;
  endfunction

  function automatic int argmax(input logic [VW-1:0] v);
    int best = 0;
    for (int e = 1; e < NI; e++)
      if (v[e*IW +: IW] > v[best*IW +: IW]) best = e;
    return best;
  endfunction

  function automatic logic [NR-1:0] oh(input int g);
    logic [NR-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    eng_res_valid = 1'b0;
    rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full transaction for requester g, which must be granted right now.
  task automatic transact(input int g);
    chk($sformatf("grant%0d", g), VW'(req_ready), VW'(oh(g)));
    tick();
    chk("launch_valid", VW'(eng_valid), VW'(1'b1));
    chk("launch_data", eng_data, mkvec(g, mx[g]));
    chk("launch_ready0", VW'(req_ready), '0);
    req_valid[g] = 1'b0;
    tick();
    chk("wait_valid0", VW'(eng_valid), '0);
    chk("wait_busy", VW'(busy), VW'(1'b1));
    eng_res = 32'(argmax(eng_data));
    eng_res_valid = 1'b1;
    tick();
    eng_res_valid = 1'b0;
    eng_res = '0;
    chk("rsp_valid", VW'(rsp_valid), VW'(oh(g)));
    chk("rsp_data", VW'(rsp_data), VW'(mx[g]));
    chk("rsp_err", VW'(rsp_err), '0);
    rsp_ready = oh(g);
    tick();
    rsp_ready = '0;
    chk("idle_rsp0", VW'(rsp_valid), '0);
    chk("idle_busy0", VW'(busy), '0);
  endtask

  initial begin
    rst_n = 1'b0;
    eng_res = '0;
    eng_res_valid = 1'b0;
    rsp_ready = '0;
    req_valid = 4'b0010;
    for (int r = 0; r < NR; r++) req_data[r*VW +: VW] = mkvec(r, mx[r]);

    // Reset state, with a request already pending.
    #3;
    chk("rst_ready", VW'(req_ready), '0);
    chk("rst_eng_valid", VW'(eng_valid), '0);
    chk("rst_eng_data", eng_data, '0);
    chk("rst_rsp_valid", VW'(rsp_valid), '0);
    chk("rst_rsp_data", VW'(rsp_data), '0);
    chk("rst_rsp_err", VW'(rsp_err), '0);
    chk("rst_busy", VW'(busy), '0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    transact(1);

    // Everyone requesting after reset: 0,1,2,3 then 0 and 2.
    do_reset();
    req_valid = 4'b1111;
    #1;
    transact(0);
    transact(1);
    transact(2);
    transact(3);
    req_valid = 4'b0101;
    #1;
    transact(0);
    transact(2);

    // Back-pressure in DELIVER; other ready bits must be ignored.
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", VW'(req_ready), VW'(4'b0100));
    tick();
    req_valid = 4'b0001;
    tick();
    eng_res = 32'(argmax(eng_data));
    eng_res_valid = 1'b1;
    tick();
    eng_res_valid = 1'b0;
    rsp_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", VW'(rsp_valid), VW'(4'b0100));
      chk("bp_rsp_data", VW'(rsp_data), VW'(mx[2]));
      chk("bp_busy", VW'(busy), VW'(1'b1));
      chk("bp_no_ready", VW'(req_ready), '0);
      tick();
    end
    chk("bp_still_valid", VW'(rsp_valid), VW'(4'b0100));
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    transact(0);

    // Engine strobe while IDLE must be ignored.
    eng_res = 32'd5;
    eng_res_valid = 1'b1;
    tick();
    eng_res_valid = 1'b0;
    chk("stray_idle_busy", VW'(busy), '0);
    chk("stray_idle_rsp", VW'(rsp_valid), '0);
    chk("stray_idle_data", VW'(rsp_data), VW'(mx[0]));
    tick();
    chk("stray_idle_busy2", VW'(busy), '0);

    // Reset while in WAIT; late result after release dropped; pointer restarts at 0.
    req_valid = 4'b0010;
    #1;
    chk("rw_grant", VW'(req_ready), VW'(4'b0010));
    tick();
    req_valid = '0;
    tick();
    chk("rw_busy", VW'(busy), VW'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rw_rst_busy", VW'(busy), '0);
    chk("rw_rst_eng_data", eng_data, '0);
    chk("rw_rst_rsp_data", VW'(rsp_data), '0);
    chk("rw_rst_rsp_valid", VW'(rsp_valid), '0);
    tick();
    tick();
    rst_n = 1'b1;
    eng_res = 32'(mx[1]);
    eng_res_valid = 1'b1;
    tick();
    eng_res_valid = 1'b0;
    chk("rw_late_rsp", VW'(rsp_valid), '0);
    chk("rw_late_busy", VW'(busy), '0);
    req_valid = 4'b1010;
    #1;
    transact(1);
    transact(3);

    // Silent engine.
    req_valid = 4'b0001;
    #1;
    chk("to_grant", VW'(req_ready), VW'(4'b0001));
    tick();
    chk("to_launch", VW'(eng_valid), VW'(1'b1));
    req_valid = '0;
`ifdef ARGMAX_ARB_TIMEOUT_EN
    for (int k = 1; k < 64; k++) begin
      tick();
      chk($sformatf("to_wait%0d", k), VW'(rsp_valid), '0);
    end
    tick();
    chk("to_rsp_valid", VW'(rsp_valid), VW'(4'b0001));
    chk("to_rsp_err", VW'(rsp_err), VW'(1'b1));
    chk("to_rsp_data", VW'(rsp_data), VW'(32'hFFFF_FFFF));
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    chk("to_idle", VW'(busy), '0);
`else
    repeat (100) tick();
    chk("nto_busy", VW'(busy), VW'(1'b1));
    chk("nto_rsp", VW'(rsp_valid), '0);
    chk("nto_err", VW'(rsp_err), '0);
    eng_res = 32'(mx[0]);
    eng_res_valid = 1'b1;
    tick();
    eng_res_valid = 1'b0;
    chk("nto_rsp_valid", VW'(rsp_valid), VW'(4'b0001));
    chk("nto_rsp_data", VW'(rsp_data), VW'(mx[0]));
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    chk("nto_idle", VW'(busy), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
